// File: rtl/shift_mult_pkg.sv
// Shared definitions for the shift-add multiplier control unit:
// FSM state encoding and default datapath widths.
package shift_mult_pkg;

  // Default multiplier width and bit-counter width (CW >= clog2(N)+1).
  localparam int N_DEF  = 16;
  localparam int CW_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Moore-decoded strobes; acc_add is handled separately since it follows lsb_in.
  typedef struct packed {
    logic ld;
    logic shen;
    logic acc_clr;
    logic acc_shen;
    logic busy;
    logic done;
  } strobe_t;

  localparam strobe_t STROBE_IDLE = '{ld: 1'b0, shen: 1'b0, acc_clr: 1'b0,
                                      acc_shen: 1'b0, busy: 1'b0, done: 1'b0};

endpackage : shift_mult_pkg

// File: rtl/bit_counter.sv
// CW-bit up counter with synchronous clear (priority over enable) and a
// terminal-count flag that is high while the count equals N-1.
module bit_counter
  import shift_mult_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  localparam logic [CW-1:0] TERM = CW'(N - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == TERM);

endmodule : bit_counter

// File: rtl/shift_mult_ctrl.sv
// Control FSM for the sequential shift-add multiplier (IDLE/LOAD/RUN/DONE).
// Define SHIFT_MULT_ABORT_EN to make the abort input cancel LOAD, RUN or DONE.
module shift_mult_ctrl
  import shift_mult_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic          ack,
  input  logic          lsb_in,
  input  logic          abort,
  output logic          ld,
  output logic          shen,
  output logic          acc_clr,
  output logic          acc_add,
  output logic          acc_shen,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cnt
);

  state_e  state_q;
  state_e  state_d;
  strobe_t strobe;
  logic    abort_go;
  logic    cnt_clr;
  logic    cnt_tc;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every variable assigned in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    abort_go = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_RUN;
      ST_RUN:  if (cnt_tc) state_d = ST_DONE;
      ST_DONE: if (ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
`ifdef SHIFT_MULT_ABORT_EN
    // Abort outranks ack and the RUN terminal transition; clr still wins above.
    if (abort && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      abort_go = 1'b1;
    end
`endif
  end

`ifndef SHIFT_MULT_ABORT_EN
  logic unused_abort;
  assign unused_abort = abort;
`endif

  // Clear on reset, on abort, and on the edge entering LOAD so LOAD shows 0.
  assign cnt_clr = clr || abort_go || ((state_q == ST_IDLE) && start);

  bit_counter #(
    .N  (N),
    .CW (CW)
  ) u_bit_counter (
    .clk (clk),
    .clr (cnt_clr),
    .en  (state_q == ST_RUN),
    .cnt (cnt),
    .tc  (cnt_tc)
  );

  always_comb begin
    strobe = STROBE_IDLE;
    unique case (state_q)
      ST_LOAD: begin
        strobe.ld      = 1'b1;
        strobe.acc_clr = 1'b1;
        strobe.busy    = 1'b1;
      end
      ST_RUN: begin
        strobe.shen     = 1'b1;
        strobe.acc_shen = 1'b1;
        strobe.busy     = 1'b1;
      end
      ST_DONE: strobe.done = 1'b1;
      default: strobe = STROBE_IDLE;
    endcase
  end

  assign ld       = strobe.ld;
  assign shen     = strobe.shen;
  assign acc_clr  = strobe.acc_clr;
  assign acc_shen = strobe.acc_shen;
  assign busy     = strobe.busy;
  assign done     = strobe.done;
  assign acc_add  = (state_q == ST_RUN) && lsb_in;

endmodule : shift_mult_ctrl

// File: tb/tb_shift_mult_ctrl.sv
// Self-checking bench for shift_mult_ctrl: expected outputs come from a
// cycle-offset model of one multiplication (LOAD, N RUN cycles, DONE).
module tb_shift_mult_ctrl;

  localparam int N  = 16;
  localparam int CW = 5;
`ifdef SHIFT_MULT_ABORT_EN
  localparam bit ABORT_ON = 1'b1;
`else
  localparam bit ABORT_ON = 1'b0;
`endif

  typedef logic [CW+6:0] vec_t;

  logic          clk = 1'b0;
  logic          clr, start, ack, lsb_in, abort;
  logic          ld, shen, acc_clr, acc_add, acc_shen, busy, done;
  logic [CW-1:0] cnt;

  int            errors = 0;
  int            checks = 0;
  int            idle_cnt = 0;

  shift_mult_ctrl #(.N(N), .CW(CW)) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .ack      (ack),
    .lsb_in   (lsb_in),
    .abort    (abort),
    .ld       (ld),
    .shen     (shen),
    .acc_clr  (acc_clr),
    .acc_add  (acc_add),
    .acc_shen (acc_shen),
    .busy     (busy),
    .done     (done),
    .cnt      (cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t obs();
    return {ld, shen, acc_clr, acc_add, acc_shen, busy, done, cnt};
  endfunction

  function automatic vec_t expv(input logic l, input logic s, input logic c, input logic a,
                                input logic as, input logic b, input logic d, input int n);
    return {l, s, c, a, as, b, d, CW'(n)};
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One operation: start in IDLE, LOAD, N RUN cycles, DONE for ack_delay+1
  // cycles, then IDLE. clr_k/abort_k (>=0) interrupt at that RUN cycle.
  task automatic run_op(input string name, input logic [N-1:0] op, input int ack_delay,
                        input bit noise, input int abort_k, input int clr_k, input bit tail);
    vec_t e;
    int   n_ld, n_shen;
    bit   cut;
    n_ld = 0; n_shen = 0; cut = 1'b0;
    start = 1'b1;
    cyc();
    start  = noise ? 1'($urandom) : 1'b0;
    ack    = noise ? 1'($urandom) : 1'b0;
    lsb_in = 1'($urandom);
    #1;
    e = expv(1, 0, 1, 0, 0, 1, 0, 0);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL %s load: got %b expected %b", name, obs(), e);
    end
    n_ld += int'(ld); n_shen += int'(shen);
    for (int k = 0; k < N && !cut; k++) begin
      cyc();
      lsb_in = op[k];
      start  = noise ? 1'($urandom) : 1'b0;
      ack    = noise ? 1'($urandom) : 1'b0;
      abort  = (k == abort_k);
      clr    = (k == clr_k);
      #1;
      e = expv(0, 1, 0, op[k], 1, 1, 0, k);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL %s run[%0d]: got %b expected %b", name, k, obs(), e);
      end
      n_ld += int'(ld); n_shen += int'(shen);
      cut = (k == clr_k) || (ABORT_ON && (k == abort_k));
    end
    if (cut) begin
      cyc();
      clr = 1'b0; abort = 1'b0; start = 1'b0; ack = 1'b0;
      #1;
      e = expv(0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL %s interrupt: got %b expected %b", name, obs(), e);
      end
      idle_cnt = 0;
      return;
    end
    abort = 1'b0;
    cyc();
    start = 1'b0; ack = 1'b0; lsb_in = 1'($urandom);
    #1;
    e = expv(0, 0, 0, 0, 0, 0, 1, N);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL %s done: got %b expected %b", name, obs(), e);
    end
    for (int i = 0; i < ack_delay; i++) begin
      cyc();
      start = noise ? 1'($urandom) : 1'b0;
      lsb_in = 1'($urandom);
      #1;
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL %s done_hold[%0d]: got %b expected %b", name, i, obs(), e);
      end
    end
    ack = 1'b1;
    start = tail;
    cyc();
    ack = 1'b0; start = 1'b0;
    #1;
    e = expv(0, 0, 0, 0, 0, 0, 0, N);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL %s ack_idle: got %b expected %b", name, obs(), e);
    end
    checks++;
    if (n_ld != 1 || n_shen != N) begin
      errors++;
      $display("FAIL %s pulses: got ld=%0d shen=%0d expected ld=1 shen=%0d", name, n_ld, n_shen, N);
    end
    idle_cnt = N;
    if (tail) begin
      cyc();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL %s stay_idle: got %b expected %b", name, obs(), e);
      end
    end
  endtask

  task automatic test_reset();
    vec_t e;
    clr = 1'b1; start = 1'b1; ack = 1'b0; abort = 1'b0; lsb_in = 1'b1;
    e = expv(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      #1;
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL reset[%0d]: got %b expected %b", i, obs(), e);
      end
    end
    clr = 1'b0;
    cyc();
    #1;
    e = expv(1, 0, 1, 0, 0, 1, 0, 0);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_release_load: got %b expected %b", obs(), e);
    end
    clr = 1'b1; start = 1'b0;
    cyc();
    clr = 1'b0;
    #1;
    e = expv(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_reidle: got %b expected %b", obs(), e);
    end
    idle_cnt = 0;
  endtask

  task automatic test_idle_quiet();
    vec_t e;
    e = expv(0, 0, 0, 0, 0, 0, 0, idle_cnt);
    for (int i = 0; i < 3; i++) begin
      ack = 1'($urandom); lsb_in = 1'($urandom); abort = 1'($urandom);
      cyc();
      #1;
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL idle_quiet[%0d]: got %b expected %b", i, obs(), e);
      end
    end
    ack = 1'b0; abort = 1'b0;
  endtask

  task automatic test_nominal();
    run_op("nominal_0005", 16'h0005, 0, 1'b0, -1, -1, 1'b1);
  endtask

  task automatic test_all_ones();
    run_op("all_ones", 16'hFFFF, 1, 1'b1, -1, -1, 1'b1);
  endtask

  task automatic test_handshake();
    run_op("handshake", 16'($urandom), 5, 1'b0, -1, -1, 1'b1);
  endtask

  task automatic test_mid_clr();
    run_op("mid_clr", 16'($urandom), 0, 1'b0, -1, 7, 1'b1);
    run_op("after_clr", 16'($urandom), 0, 1'b0, -1, -1, 1'b1);
  endtask

  task automatic test_abort();
    run_op("abort", 16'($urandom), 0, 1'b0, 4, -1, 1'b1);
    run_op("after_abort", 16'($urandom), 0, 1'b0, -1, -1, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      run_op("b2b", 16'($urandom), 0, 1'b0, -1, -1, 1'b0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_op("random", 16'($urandom), int'($urandom_range(0, 3)), 1'b1, -1, -1,
             1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_idle_quiet();
    test_nominal();
    test_all_ones();
    test_handshake();
    test_mid_clr();
    test_abort();
    test_idle_quiet();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_shift_mult_ctrl
